// File: rtl/dsi_tx_scheduler.sv
// DSI transmit scheduler: arbitrates between an HS and an LP packet source,
// sequences LP mode entry/exit around the lane controller handshake, and
// flags underruns on the granted source.
module dsi_tx_scheduler #(
  parameter int unsigned LP_GUARD_CYCLES = 2,  // 1..15
  parameter int unsigned STARVE_LIMIT    = 4   // 1..15
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        hs_valid,
  input  logic [31:0] hs_data,
  input  logic [3:0]  hs_strb,
  input  logic        hs_last,
  output logic        hs_ack,
  input  logic        lp_valid,
  input  logic [31:0] lp_data,
  input  logic [3:0]  lp_strb,
  input  logic        lp_last,
  output logic        lp_ack,
  input  logic        lanes_ready,
  input  logic        lines_active,
  input  logic        iface_data_rqst,
  output logic [31:0] iface_write_data,
  output logic [3:0]  iface_write_strb,
  output logic        iface_write_rqst,
  output logic        iface_last_word,
  output logic        iface_lpm_en,
  output logic        grant_hs,
  output logic        grant_lp,
  output logic        busy,
  output logic        err_underrun
);

  typedef enum logic [2:0] {IDLE, LP_SETUP, SEND, LP_HOLD, WAIT_DONE} state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } src_word_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);
  localparam logic [3:0] GUARD_LAST = 4'(LP_GUARD_CYCLES - 1);

  state_t     state_q, state_d;
  logic       sel_lp_q, sel_lp_d;   // owner of the current packet
  logic [3:0] starve_q, starve_d;   // HS grants taken while LP waited
  logic [3:0] guard_q, guard_d;     // cycles spent in LP_SETUP
  logic       err_q, err_d;
  logic       armed_q;              // blocks a grant on the first edge after reset

  src_word_t hs_w, lp_w, g_w;

  assign hs_w = '{valid: hs_valid, data: hs_data, strb: hs_strb, last: hs_last};
  assign lp_w = '{valid: lp_valid, data: lp_data, strb: lp_strb, last: lp_last};
  assign g_w  = sel_lp_q ? lp_w : hs_w;

  assign err_underrun = err_q;
  assign busy         = (state_q != IDLE);

  // State and bookkeeping registers; reset drops everything back to IDLE.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_lp_q <= 1'b0;
      starve_q <= '0;
      guard_q  <= '0;
      err_q    <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_lp_q <= sel_lp_d;
      starve_q <= starve_d;
      guard_q  <= guard_d;
      err_q    <= err_d;
      armed_q  <= 1'b1;
    end
  end

  // Arbitration, next state and all lane-controller facing outputs.
  always_comb begin
    state_d          = state_q;
    sel_lp_d         = sel_lp_q;
    starve_d         = starve_q;
    guard_d          = guard_q;
    err_d            = err_q;
    hs_ack           = 1'b0;
    lp_ack           = 1'b0;
    iface_write_data = '0;
    iface_write_strb = '0;
    iface_write_rqst = 1'b0;
    iface_last_word  = 1'b0;
    iface_lpm_en     = 1'b0;
    grant_hs         = 1'b0;
    grant_lp         = 1'b0;

    case (state_q)
      IDLE: begin
        if (armed_q && lanes_ready && !lines_active) begin
          if (hs_valid && !(lp_valid && starve_q >= STARVE_LIM)) begin
            state_d  = SEND;
            sel_lp_d = 1'b0;
            if (lp_valid && starve_q != 4'hF) starve_d = starve_q + 4'd1;
          end else if (lp_valid) begin
            state_d  = LP_SETUP;
            sel_lp_d = 1'b1;
            starve_d = '0;
            guard_d  = '0;
          end
        end
      end

      // LP mode is asserted but no word is offered until the guard expires.
      LP_SETUP: begin
        grant_lp     = 1'b1;
        iface_lpm_en = 1'b1;
        if (guard_q == GUARD_LAST) state_d = SEND;
        else                       guard_d = guard_q + 4'd1;
      end

      SEND: begin
        grant_hs         = !sel_lp_q;
        grant_lp         = sel_lp_q;
        iface_lpm_en     = sel_lp_q;
        iface_write_rqst = g_w.valid;
        iface_write_data = g_w.data;
        iface_write_strb = g_w.strb;
        hs_ack           = !sel_lp_q && iface_data_rqst;
        lp_ack           = sel_lp_q && iface_data_rqst;
        // Every SEND cycle precedes the last word, so a gap is an underrun.
        if (!g_w.valid) err_d = 1'b1;
        if (iface_data_rqst && g_w.valid && g_w.last) begin
          iface_last_word = 1'b1;
          state_d         = sel_lp_q ? LP_HOLD : WAIT_DONE;
        end
      end

      // Keep LP mode one cycle past the final word before releasing it.
      LP_HOLD: begin
        grant_lp     = 1'b1;
        iface_lpm_en = 1'b1;
        state_d      = WAIT_DONE;
      end

      WAIT_DONE: begin
        if (!lines_active) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dsi_tx_scheduler.sv
// Directed bench for dsi_tx_scheduler with default parameters
// (LP_GUARD_CYCLES=2, STARVE_LIMIT=4).
module tb_dsi_tx_scheduler;

  logic        clk_sys = 1'b0;
  logic        rst;
  logic        hs_valid, hs_last, hs_ack;
  logic [31:0] hs_data;
  logic [3:0]  hs_strb;
  logic        lp_valid, lp_last, lp_ack;
  logic [31:0] lp_data;
  logic [3:0]  lp_strb;
  logic        lanes_ready, lines_active, iface_data_rqst;
  logic [31:0] iface_write_data;
  logic [3:0]  iface_write_strb;
  logic        iface_write_rqst, iface_last_word, iface_lpm_en;
  logic        grant_hs, grant_lp, busy, err_underrun;

  int total = 0;
  int bad   = 0;
  int n;

  dsi_tx_scheduler dut (
    .clk_sys(clk_sys), .rst(rst),
    .hs_valid(hs_valid), .hs_data(hs_data), .hs_strb(hs_strb), .hs_last(hs_last), .hs_ack(hs_ack),
    .lp_valid(lp_valid), .lp_data(lp_data), .lp_strb(lp_strb), .lp_last(lp_last), .lp_ack(lp_ack),
    .lanes_ready(lanes_ready), .lines_active(lines_active), .iface_data_rqst(iface_data_rqst),
    .iface_write_data(iface_write_data), .iface_write_strb(iface_write_strb),
    .iface_write_rqst(iface_write_rqst), .iface_last_word(iface_last_word),
    .iface_lpm_en(iface_lpm_en), .grant_hs(grant_hs), .grant_lp(grant_lp),
    .busy(busy), .err_underrun(err_underrun)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic cyc();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    hs_valid = 1'b1; hs_data = '0; hs_strb = '0; hs_last = 1'b0;
    lp_valid = 1'b0; lp_data = '0; lp_strb = '0; lp_last = 1'b0;
    lanes_ready = 1'b1; lines_active = 1'b0; iface_data_rqst = 1'b1;
    #2;
    // reset state
    chk("rst_busy", busy, 0);
    chk("rst_grant_hs", grant_hs, 0);
    chk("rst_grant_lp", grant_lp, 0);
    chk("rst_lpm", iface_lpm_en, 0);
    chk("rst_err", err_underrun, 0);
    chk("rst_rqst", iface_write_rqst, 0);
    chk("rst_hs_ack", hs_ack, 0);
    cyc();
    chk("rst_hold_busy", busy, 0);

    // lanes not ready: nothing granted even with both sources waiting
    rst = 1'b0;
    lanes_ready = 1'b0; hs_valid = 1'b1; lp_valid = 1'b1; iface_data_rqst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("nolane_busy", busy, 0);
      chk("nolane_grant", {grant_hs, grant_lp}, 2'b00);
    end

    // 3-word HS packet
    lanes_ready = 1'b1;
    cyc();
    chk("hs_grant", grant_hs, 1);
    chk("hs_grant_lp", grant_lp, 0);
    chk("hs_lpm", iface_lpm_en, 0);
    hs_data = 32'hA000_0001; hs_strb = 4'hF; iface_data_rqst = 1'b1;
    #1;
    chk("hs_w0_rqst", iface_write_rqst, 1);
    chk("hs_w0_data", iface_write_data, 32'hA000_0001);
    chk("hs_w0_ack", hs_ack, 1);
    chk("hs_w0_lpack", lp_ack, 0);
    chk("hs_w0_last", iface_last_word, 0);
    cyc();
    hs_data = 32'hA000_0002; iface_data_rqst = 1'b0;
    #1;
    chk("hs_stall_rqst", iface_write_rqst, 1);
    chk("hs_stall_ack", hs_ack, 0);
    cyc();
    iface_data_rqst = 1'b1;
    #1;
    chk("hs_w1_ack", hs_ack, 1);
    chk("hs_w1_data", iface_write_data, 32'hA000_0002);
    cyc();
    hs_data = 32'hA000_0003; hs_strb = 4'h3; hs_last = 1'b1; lines_active = 1'b1;
    #1;
    chk("hs_w2_last", iface_last_word, 1);
    chk("hs_w2_ack", hs_ack, 1);
    chk("hs_w2_strb", iface_write_strb, 4'h3);
    cyc();
    chk("hs_wait_grant", grant_hs, 0);
    chk("hs_wait_busy", busy, 1);
    chk("hs_wait_rqst", iface_write_rqst, 0);
    hs_valid = 1'b0; lp_valid = 1'b0; hs_last = 1'b0; iface_data_rqst = 1'b0;
    cyc();
    chk("hs_wait_active", busy, 1);
    lines_active = 1'b0;
    cyc();
    chk("hs_idle", busy, 0);
    chk("hs_noerr", err_underrun, 0);

    // 2-word LP packet with guard period and hold cycle
    lp_valid = 1'b1; lp_data = 32'hB000_0001; lp_strb = 4'hF;
    cyc();
    chk("lp_setup_lpm", iface_lpm_en, 1);
    chk("lp_setup_grant", grant_lp, 1);
    chk("lp_setup_rqst", iface_write_rqst, 0);
    cyc();
    chk("lp_setup2_lpm", iface_lpm_en, 1);
    chk("lp_setup2_rqst", iface_write_rqst, 0);
    cyc();
    iface_data_rqst = 1'b1; hs_valid = 1'b1;
    #1;
    chk("lp_w0_rqst", iface_write_rqst, 1);
    chk("lp_w0_data", iface_write_data, 32'hB000_0001);
    chk("lp_w0_ack", lp_ack, 1);
    chk("lp_w0_hsack", hs_ack, 0);
    cyc();
    lp_data = 32'hB000_0002; lp_last = 1'b1; hs_valid = 1'b0;
    #1;
    chk("lp_w1_last", iface_last_word, 1);
    chk("lp_w1_lpm", iface_lpm_en, 1);
    cyc();
    chk("lp_hold_lpm", iface_lpm_en, 1);
    chk("lp_hold_rqst", iface_write_rqst, 0);
    chk("lp_hold_last", iface_last_word, 0);
    lp_valid = 1'b0; lp_last = 1'b0; iface_data_rqst = 1'b0;
    cyc();
    chk("lp_done_lpm", iface_lpm_en, 0);
    chk("lp_done_grant", grant_lp, 0);
    cyc();
    chk("lp_idle", busy, 0);

    // HS underrun mid-packet
    hs_valid = 1'b1; hs_data = 32'hC000_0001; hs_last = 1'b0;
    cyc();
    iface_data_rqst = 1'b1;
    #1;
    chk("ur_w0_rqst", iface_write_rqst, 1);
    cyc();
    hs_valid = 1'b0; iface_data_rqst = 1'b0;
    #1;
    chk("ur_gap_rqst", iface_write_rqst, 0);
    cyc();
    hs_valid = 1'b1; hs_last = 1'b1; iface_data_rqst = 1'b1;
    #1;
    chk("ur_err_set", err_underrun, 1);
    chk("ur_still_send", grant_hs, 1);
    chk("ur_last", iface_last_word, 1);
    cyc();
    hs_valid = 1'b0; hs_last = 1'b0; iface_data_rqst = 1'b0;
    cyc();
    chk("ur_idle", busy, 0);
    chk("ur_err_sticky", err_underrun, 1);

    // reset during LP SEND, then a full guard period on restart
    lp_valid = 1'b1; lp_data = 32'hD000_0001;
    cyc();
    cyc();
    cyc();
    iface_data_rqst = 1'b1;
    #1;
    chk("rs_send_rqst", iface_write_rqst, 1);
    rst = 1'b1;
    #1;
    chk("rs_rqst", iface_write_rqst, 0);
    chk("rs_lpm", iface_lpm_en, 0);
    chk("rs_grant", grant_lp, 0);
    chk("rs_ack", lp_ack, 0);
    chk("rs_busy", busy, 0);
    chk("rs_err", err_underrun, 0);
    chk("rs_data", iface_write_data, 0);
    chk("rs_last", iface_last_word, 0);
    cyc();
    rst = 1'b0; iface_data_rqst = 1'b0;
    cyc();
    chk("rs_first_edge", busy, 0);
    cyc();
    chk("rs_re_lpm", iface_lpm_en, 1);
    chk("rs_re_rqst0", iface_write_rqst, 0);
    cyc();
    chk("rs_re_rqst1", iface_write_rqst, 0);
    cyc();
    chk("rs_re_send", iface_write_rqst, 1);
    lp_last = 1'b1; iface_data_rqst = 1'b1;
    cyc();
    lp_valid = 1'b0; lp_last = 1'b0; iface_data_rqst = 1'b0;
    cyc();
    cyc();
    chk("rs_re_idle", busy, 0);

    // starvation: both sources always valid -> HS,HS,HS,HS,LP repeating
    hs_valid = 1'b1; lp_valid = 1'b1; hs_last = 1'b1; lp_last = 1'b1;
    iface_data_rqst = 1'b1; lines_active = 1'b0;
    for (int p = 0; p < 10; p++) begin
      cyc();
      chk("arb_hs", grant_hs, (p % 5 == 4) ? 0 : 1);
      chk("arb_lp", grant_lp, (p % 5 == 4) ? 1 : 0);
      n = 0;
      while (busy && n < 12) begin
        cyc();
        n++;
      end
      chk("arb_drain", busy, 0);
    end
    hs_valid = 1'b0; lp_valid = 1'b0; iface_data_rqst = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
